// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   state_t         - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN/PAR_ODD - values of the PAR_TYP input
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts clock cycles within one serial bit.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - hold the count at 0 (used while the line is idle)
//   bit_done  - high on the last cycle of a bit; the count wraps to 0 after it
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  // With CLKS_PER_BIT=1 the count stays at 0 and bit_done is constantly high.
  assign bit_done = (cnt_q == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
//   CLK, RST    - clock, asynchronous active-high reset
//   P_DATA      - parallel word, latched when accepted
//   DATA_VALID  - request; accepted only in IDLE
//   PAR_EN      - insert parity bit; PAR_TYP 0=even, 1=odd
//   TX_OUT      - serial line, idles high (registered)
//   busy        - frame in progress (registered)
// Frame: start(0), DATA_WIDTH data bits LSB-first, optional parity, stop(1),
// each held CLKS_PER_BIT cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                  state_q, state_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_bit_q, par_bit_d;
  logic                    par_en_q, par_en_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    bit_done;

  // Timer is held at 0 in IDLE, so the START bit always begins at count 0;
  // every other transition happens on bit_done, where the timer wraps anyway.
  uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .clear    (state_q == IDLE),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;

    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d   = START;
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line changes
    // on the same edge as the state itself.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + randomized bench for uart_tx (DATA_WIDTH=8,
// CLKS_PER_BIT=4). Expected line levels come from a frame model built
// from the bit-list definition of a UART frame.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          busy;

  int checks = 0;
  int errors = 0;

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bounded wait for the line to go idle, then present a word at a negedge
  // and return 1 time unit after the accepting edge. DATA_VALID stays high.
  task automatic start_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_before_start", busy, 1'b0);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Called 1 unit after the accept edge k. Checks every cycle of the frame
  // and the idle state at edge k+F; returns 1 unit after edge k+F.
  task automatic check_frame(input string tag, input logic [DW-1:0] d,
                             input logic pen, input logic ptyp);
    logic bits [0:DW+2];
    int   nb;
    int   ones;
    ones = $countones(d);
    nb = 0;
    bits[nb++] = 1'b0;
    for (int b = 0; b < DW; b++) bits[nb++] = d[b];
    if (pen) begin
      // Choose the bit that makes the total count of ones even (or odd).
      if (ptyp == PAR_ODD) bits[nb++] = ((ones % 2) == 0);
      else                 bits[nb++] = ((ones % 2) == 1);
    end
    bits[nb++] = 1'b1;
    for (int i = 0; i < nb * CPB; i++) begin
      chk({tag, "_tx"},   TX_OUT, bits[i / CPB]);
      chk({tag, "_busy"}, busy,   1'b1);
      @(posedge CLK); #1;
    end
    chk({tag, "_end_tx"},   TX_OUT, 1'b1);
    chk({tag, "_end_busy"}, busy,   1'b0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          rp, rt;

    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;

    // Reset and idle
    repeat (3) begin
      @(negedge CLK);
      chk("rst_tx", TX_OUT, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    RST = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      chk("idle_tx", TX_OUT, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end

    // 0xA5 without parity, then even and odd parity
    start_frame(8'hA5, 1'b0, PAR_EVEN); DATA_VALID = 1'b0;
    check_frame("a5_nopar", 8'hA5, 1'b0, PAR_EVEN);
    start_frame(8'hA5, 1'b1, PAR_EVEN); DATA_VALID = 1'b0;
    check_frame("a5_even", 8'hA5, 1'b1, PAR_EVEN);
    start_frame(8'hA5, 1'b1, PAR_ODD); DATA_VALID = 1'b0;
    check_frame("a5_odd", 8'hA5, 1'b1, PAR_ODD);

    // Back-to-back: inputs change after the accept edge, DATA_VALID held high
    start_frame(8'h00, 1'b0, PAR_EVEN);
    P_DATA = 8'hFF; PAR_EN = 1'b0;
    check_frame("b2b_first", 8'h00, 1'b0, PAR_EVEN);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    check_frame("b2b_second", 8'hFF, 1'b0, PAR_EVEN);

    // Ignored request mid-frame, and no extra frame afterwards
    start_frame(8'hA5, 1'b1, PAR_EVEN); DATA_VALID = 1'b0;
    fork
      check_frame("ignored", 8'hA5, 1'b1, PAR_EVEN);
      begin
        repeat (14) @(negedge CLK);
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
      end
    join
    repeat (50) begin
      @(negedge CLK);
      chk("no_extra_tx", TX_OUT, 1'b1);
      chk("no_extra_busy", busy, 1'b0);
    end

    // Randomized words and parity settings
    for (int n = 0; n < 8; n++) begin
      rd = DW'($urandom);
      rp = 1'($urandom);
      rt = 1'($urandom);
      start_frame(rd, rp, rt); DATA_VALID = 1'b0;
      check_frame("rand", rd, rp, rt);
    end

    // Reset asserted during data bit 3 (cycles 4*CPB..5*CPB-1 of the frame)
    rd = DW'($urandom);
    start_frame(rd, 1'b0, PAR_EVEN); DATA_VALID = 1'b0;
    repeat (4 * CPB + 1) @(posedge CLK);
    #2;
    chk("pre_rst_bit3", TX_OUT, rd[3]);
    #1 RST = 1'b1;
    #1;
    chk("midrst_tx", TX_OUT, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk("post_rst_tx", TX_OUT, 1'b1);
      chk("post_rst_busy", busy, 1'b0);
    end
    rd = DW'($urandom);
    start_frame(rd, 1'b1, PAR_ODD); DATA_VALID = 1'b0;
    check_frame("post_rst_frame", rd, 1'b1, PAR_ODD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
